// File: rtl/router_rx_deser.sv
// ---------------------------------------------------------------------------
// router_rx_deser
// Per-input-port deserializer for the 16-port router. It decodes the serial
// frame protocol into bytes and queues them for the switch fabric:
//   destination address (DA_WIDTH bits, LSB first)
//   -> PAD_CYCLES pad cycles
//   -> payload bits (LSB first, qualified by valid_n), with frame_n rising
//      on the last bit.
// Each byte is tagged with its destination address and an end-of-frame flag.
// The tagged bytes go into a FIFO_DEPTH-entry FIFO, drained by valid/ready.
//
// Ports
//   clock, reset_n          : clock and async active-low reset
//   din, frame_n, valid_n   : serial input pins
//   out_data/out_da/out_last: FIFO head entry; out_valid when non-empty,
//                             popped on out_valid && out_ready
//   da_valid, da            : address-captured pulse; address held afterwards
//   err, err_code           : framing error pulse and its cause
//                             (1 short header, 2 pad violation,
//                              3 bad termination)
//   ovf                     : pulse when a completed byte is dropped because
//                             the FIFO is full
// ---------------------------------------------------------------------------
module router_rx_deser #(
  parameter int FIFO_DEPTH = 8,
  parameter int PAD_CYCLES = 5,
  parameter int DA_WIDTH   = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                din,
  input  logic                frame_n,
  input  logic                valid_n,
  output logic [7:0]          out_data,
  output logic [DA_WIDTH-1:0] out_da,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                da_valid,
  output logic [DA_WIDTH-1:0] da,
  output logic                err,
  output logic [1:0]          err_code,
  output logic                ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = (DA_WIDTH > 1) ? $clog2(DA_WIDTH) : 1;
  localparam int PAD_W = (PAD_CYCLES > 1) ? $clog2(PAD_CYCLES) : 1;
  localparam int ENT_W = 1 + DA_WIDTH + 8;
  localparam logic [BIT_W-1:0] DA_LAST  = BIT_W'(DA_WIDTH - 1);
  localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(PAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_PAD  = 3'd2,
    ST_DATA = 3'd3,
    ST_DROP = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [BIT_W-1:0]    bit_cnt_r, bit_cnt_s;
  logic [PAD_W-1:0]    pad_cnt_r, pad_cnt_s;
  logic [2:0]          bcnt_r, bcnt_s;
  logic [6:0]          shreg_r, shreg_s;
  logic [DA_WIDTH-1:0] da_sh_r, da_sh_s;
  logic [DA_WIDTH-1:0] da_r;
  logic                da_load_s, da_valid_r;
  logic                err_s, err_r;
  logic [1:0]          err_code_s, err_code_r;
  logic                wr_s, wr_last_s;
  logic [7:0]          wr_byte_s;
  logic                pop_s, push_s, full_s, ovf_s, ovf_r;

  logic [ENT_W-1:0]    mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    count_r;

  // Frame decoder: next state, counters, byte assembly and error detection
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    pad_cnt_s  = pad_cnt_r;
    bcnt_s     = bcnt_r;
    shreg_s    = shreg_r;
    da_sh_s    = da_sh_r;
    da_load_s  = 1'b0;
    err_s      = 1'b0;
    err_code_s = 2'd0;
    wr_s       = 1'b0;
    wr_byte_s  = {din, shreg_r};
    wr_last_s  = frame_n;
    case (state_r)
      ST_IDLE: begin
        bcnt_s    = 3'd0;
        pad_cnt_s = {PAD_W{1'b0}};
        if (!frame_n) begin
          da_sh_s    = {DA_WIDTH{1'b0}};
          da_sh_s[0] = din;
          bit_cnt_s  = BIT_W'(1);
          state_s    = ST_ADDR;
        end else begin
          bit_cnt_s  = {BIT_W{1'b0}};
        end
      end
      ST_ADDR: begin
        if (frame_n) begin
          // Short header: the partial address never reaches da.
          err_s      = 1'b1;
          err_code_s = 2'd1;
          bit_cnt_s  = {BIT_W{1'b0}};
          state_s    = ST_IDLE;
        end else begin
          da_sh_s[bit_cnt_r] = din;
          if (bit_cnt_r == DA_LAST) begin
            da_load_s = 1'b1;
            bit_cnt_s = {BIT_W{1'b0}};
            pad_cnt_s = {PAD_W{1'b0}};
            state_s   = ST_PAD;
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_W'(1);
          end
        end
      end
      ST_PAD: begin
        // frame_n is tested first so an early end outranks a pad violation.
        if (frame_n) begin
          err_s      = 1'b1;
          err_code_s = 2'd1;
          state_s    = ST_IDLE;
        end else if (!valid_n) begin
          err_s      = 1'b1;
          err_code_s = 2'd2;
          state_s    = ST_DROP;
        end else if (pad_cnt_r == PAD_LAST) begin
          pad_cnt_s  = {PAD_W{1'b0}};
          bcnt_s     = 3'd0;
          state_s    = ST_DATA;
        end else begin
          pad_cnt_s  = pad_cnt_r + PAD_W'(1);
        end
      end
      ST_DATA: begin
        if (!valid_n) begin
          if (bcnt_r == 3'd7) begin
            wr_s   = 1'b1;
            bcnt_s = 3'd0;
          end else begin
            shreg_s[bcnt_r] = din;
            bcnt_s          = bcnt_r + 3'd1;
          end
        end else begin
          bcnt_s = bcnt_r;
        end
        if (frame_n) begin
          // Only a valid 8th bit may end the frame; otherwise the partial
          // byte is lost and the bytes already queued keep last=0.
          state_s = ST_IDLE;
          bcnt_s  = 3'd0;
          if (valid_n || (bcnt_r != 3'd7)) begin
            err_s      = 1'b1;
            err_code_s = 2'd3;
          end else begin
            err_s      = 1'b0;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_DROP: begin
        if (frame_n) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FIFO control: a write into a full FIFO survives only alongside a pop
  always_comb begin
    pop_s  = (count_r != {CNT_W{1'b0}}) && out_ready;
    full_s = (count_r == CNT_FULL);
    push_s = wr_s && (!full_s || pop_s);
    ovf_s  = wr_s && full_s && !pop_s;
  end

  // Decoder state, captured address and registered status pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= {BIT_W{1'b0}};
      pad_cnt_r  <= {PAD_W{1'b0}};
      bcnt_r     <= 3'd0;
      shreg_r    <= 7'd0;
      da_sh_r    <= {DA_WIDTH{1'b0}};
      da_r       <= {DA_WIDTH{1'b0}};
      da_valid_r <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= 2'd0;
      ovf_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      pad_cnt_r  <= pad_cnt_s;
      bcnt_r     <= bcnt_s;
      shreg_r    <= shreg_s;
      da_sh_r    <= da_sh_s;
      da_r       <= da_load_s ? da_sh_s : da_r;
      da_valid_r <= da_load_s;
      err_r      <= err_s;
      err_code_r <= err_code_s;
      ovf_r      <= ovf_s;
    end
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {ENT_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {wr_last_s, da_r, wr_byte_s};
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign {out_last, out_da, out_data} = mem_r[rd_ptr_r];
  assign out_valid = (count_r != {CNT_W{1'b0}});
  assign da_valid  = da_valid_r;
  assign da        = da_r;
  assign err       = err_r;
  assign err_code  = err_code_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_router_rx_deser.sv
module tb_router_rx_deser;
  localparam int DEPTH = 8;
  localparam int PAD   = 5;
  localparam int DAW   = 4;

  logic clock = 1'b0, reset_n = 1'b0;
  logic din = 1'b0, frame_n = 1'b1, valid_n = 1'b1, out_ready = 1'b0;
  logic [7:0] out_data;
  logic [DAW-1:0] out_da, da;
  logic out_last, out_valid, da_valid, err, ovf;
  logic [1:0] err_code;

  router_rx_deser #(.FIFO_DEPTH(DEPTH), .PAD_CYCLES(PAD), .DA_WIDTH(DAW)) dut (
    .clock(clock), .reset_n(reset_n), .din(din), .frame_n(frame_n),
    .valid_n(valid_n), .out_data(out_data), .out_da(out_da),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .da_valid(da_valid), .da(da), .err(err), .err_code(err_code), .ovf(ovf)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic           last;
    logic [DAW-1:0] da;
    logic [7:0]     data;
  } ent_t;

  int checks = 0, errors = 0;

  // Per-cycle annotations from the driver: what this input cycle should cause.
  bit ev_wr = 1'b0, ev_err = 1'b0, ev_dav = 1'b0;
  ent_t ev_ent = '0;
  logic [1:0] ev_code = 2'd0;
  logic [DAW-1:0] ev_da = '0;

  // Reference model state: expected FIFO contents and expected pulses.
  ent_t q[$];
  logic m_err = 1'b0, m_ovf = 1'b0, m_dav = 1'b0;
  logic [1:0] m_code = 2'd0;
  logic [DAW-1:0] m_da = '0;

  int ready_mode = 0;  // 0 hold low, 1 hold high, 2 random
  bit rdy_on_wr = 1'b0;
  logic [7:0] pay[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One input cycle: drive at the negedge, let the model sample the posedge.
  task automatic tick(input logic d, input logic f, input logic v);
    din = d; frame_n = f; valid_n = v;
    case (ready_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (rdy_on_wr && ev_wr) out_ready = 1'b1;
    @(posedge clock);
    #1;
    ev_wr = 1'b0; ev_err = 1'b0; ev_dav = 1'b0;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'($urandom), 1'b1, 1'($urandom));
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, 8'h00);
    chk({tag, "_out_da_last"}, {out_da, out_last}, '0);
    chk({tag, "_da"}, da, '0);
    chk({tag, "_pulses"}, {da_valid, err, ovf}, 3'b000);
    chk({tag, "_err_code"}, err_code, 2'd0);
  endtask

  task automatic header(input logic [DAW-1:0] a);
    tick(a[0], 1'b0, 1'b1);
    for (int i = 1; i < DAW; i++) begin
      if (i == DAW - 1) begin ev_dav = 1'b1; ev_da = a; end
      tick(a[i], 1'b0, 1'b1);
    end
  endtask

  // Send a frame carrying the first nbits of pay[]. bub: 0 none, 1 every other
  // payload cycle, 2 random. term_bub ends the frame on a bubble cycle.
  // rst_at >= 0 asserts reset just before that payload bit.
  task automatic send_frame(input logic [DAW-1:0] a, input int nbits, input int bub,
                            input bit term_bub, input int rst_at);
    header(a);
    repeat (PAD) tick(1'($urandom), 1'b0, 1'b1);
    for (int k = 0; k < nbits; k++) begin
      logic last;
      logic [7:0] cur;
      if (k > 0 && ((bub == 1 && k % 2 == 1) || (bub == 2 && $urandom_range(0, 2) == 0)))
        tick(1'($urandom), 1'b0, 1'b1);
      if (k == rst_at) begin
        #2 reset_n = 1'b0;
        frame_n = 1'b1; valid_n = 1'b1;
        #1 reset_check("midrst");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        return;
      end
      cur = pay[k / 8];
      last = !term_bub && (k == nbits - 1);
      if (k % 8 == 7) begin ev_wr = 1'b1; ev_ent = '{last: last, da: a, data: cur}; end
      if (last && k % 8 != 7) begin ev_err = 1'b1; ev_code = 2'd3; end
      tick(cur[k % 8], last, 1'b0);
    end
    if (term_bub) begin
      ev_err = 1'b1; ev_code = 2'd3;
      tick(1'($urandom), 1'b1, 1'b1);
    end
  endtask

  // Pad violation at pad cycle p (or early frame end when early_end is set).
  task automatic pad_err(input logic [DAW-1:0] a, input int p, input bit early_end);
    header(a);
    for (int i = 0; i < p; i++) tick(1'($urandom), 1'b0, 1'b1);
    ev_err = 1'b1;
    if (early_end) begin
      ev_code = 2'd1;
      tick(1'($urandom), 1'b1, 1'($urandom));
    end else begin
      ev_code = 2'd2;
      tick(1'($urandom), 1'b0, 1'b0);
      repeat ($urandom_range(1, 6)) tick(1'($urandom), 1'b0, 1'($urandom));
      tick(1'($urandom), 1'b1, 1'($urandom));
    end
  endtask

  // Address cut short: frame_n rises while address bit k is due.
  task automatic addr_err(input logic [DAW-1:0] a, input int k);
    tick(a[0], 1'b0, 1'b1);
    for (int i = 1; i < k; i++) tick(a[i], 1'b0, 1'b1);
    ev_err = 1'b1; ev_code = 2'd1;
    tick(a[k], 1'b1, 1'b1);
  endtask

  task automatic fill_pay(input int n);
    pay.delete();
    repeat (n) pay.push_back(8'($urandom));
  endtask

  // Reference model: FIFO occupancy as a queue, pulses one cycle after cause.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_err <= 1'b0; m_ovf <= 1'b0; m_dav <= 1'b0; m_code <= 2'd0; m_da <= '0;
    end else begin
      if (q.size() != 0 && out_ready) begin
        void'(q.pop_front());
        if (ev_wr) q.push_back(ev_ent);
        m_ovf <= 1'b0;
      end else if (ev_wr && q.size() == DEPTH) begin
        m_ovf <= 1'b1;
      end else begin
        m_ovf <= 1'b0;
        if (ev_wr) q.push_back(ev_ent);
      end
      m_err  <= ev_err;
      m_code <= ev_code;
      m_dav  <= ev_dav;
      if (ev_dav) m_da <= ev_da;
    end
  end

  // Monitor: compare DUT outputs with the model away from the active edge.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0 && out_valid === 1'b1) begin
        chk("out_data", out_data, q[0].data);
        chk("out_da", out_da, q[0].da);
        chk("out_last", out_last, q[0].last);
      end
      chk("err", err, m_err);
      if (m_err) chk("err_code", err_code, m_code);
      chk("ovf", ovf, m_ovf);
      chk("da_valid", da_valid, m_dav);
      chk("da", da, m_da);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #3 reset_check("reset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Contiguous frame, then the same with bubbles.
    ready_mode = 1;
    pay = '{8'h5A, 8'h3C};
    send_frame(4'hA, 16, 0, 1'b0, -1);
    idle(4);
    send_frame(4'hA, 16, 1, 1'b0, -1);
    idle(3);

    // 12-bit payload (bad termination), then back-to-back good frame.
    pay = '{8'hFF, 8'h0B};
    send_frame(4'h6, 12, 0, 1'b0, -1);
    pay = '{8'h01};
    send_frame(4'h3, 8, 0, 1'b0, -1);
    idle(2);

    // Pad violation in 2nd pad cycle, recovery, short header, pad priority.
    pad_err(4'h9, 1, 1'b0);
    pay = '{8'hC3};
    send_frame(4'h5, 8, 0, 1'b0, -1);
    addr_err(4'hE, 2);
    pad_err(4'h2, 3, 1'b1);
    idle(2);

    // Overflow: 10 bytes into 8 entries, then a write while full plus a pop.
    ready_mode = 0;
    fill_pay(10);
    send_frame(4'h7, 80, 0, 1'b0, -1);
    idle(2);
    rdy_on_wr = 1'b1;
    fill_pay(1);
    send_frame(4'h4, 8, 0, 1'b0, -1);
    rdy_on_wr = 1'b0;
    ready_mode = 1;
    idle(12);

    // Reset mid-DATA with 3 bytes queued, then a clean frame.
    ready_mode = 0;
    fill_pay(5);
    send_frame(4'hB, 40, 0, 1'b0, 28);
    ready_mode = 1;
    pay = '{8'h81};
    send_frame(4'hF, 8, 0, 1'b0, -1);
    idle(3);

    // Randomized mix of frame kinds with random back-pressure.
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      int kind, nb;
      kind = $urandom_range(0, 5);
      nb = $urandom_range(1, 4);
      fill_pay(nb + 1);
      case (kind)
        0, 1, 2: send_frame(4'($urandom), nb * 8, $urandom_range(0, 2), 1'b0, -1);
        3: begin
          if ($urandom_range(0, 1) == 1)
            send_frame(4'($urandom), nb * 8 + $urandom_range(1, 7), $urandom_range(0, 2), 1'b0, -1);
          else
            send_frame(4'($urandom), nb * 8 + $urandom_range(0, 7), $urandom_range(0, 2), 1'b1, -1);
        end
        4: pad_err(4'($urandom), $urandom_range(0, PAD - 1), 1'($urandom));
        default: addr_err(4'($urandom), $urandom_range(1, DAW - 1));
      endcase
      idle($urandom_range(0, 3));
    end

    ready_mode = 1;
    idle(20);
    chk("drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
